timestamp_readout: RTL and testbench

TIMESTAMP_READOUT -- requirements
Module: timestamp_readout

---
 rtl/timestamp_readout.sv | 141 ++++++++++++++
 tb/tb_timestamp_readout.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/timestamp_readout.sv
// Timestamp capture FIFO: stores {time_in, data_in} records and reads them out as four 16-bit words.
// Optional feature macro: READOUT_DROP_COUNT_EN adds a saturating drop_count output.
module timestamp_readout #(
  parameter int DEPTH_LOG2 = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  capture,
  input  logic [47:0]           time_in,
  input  logic [15:0]           data_in,
  input  logic                  data_read,
  input  logic                  clr_ovf,
  output logic [15:0]           data_out,
  output logic                  rdy,
`ifdef READOUT_DROP_COUNT_EN
  output logic [15:0]           drop_count,
`endif
  output logic [DEPTH_LOG2:0]   rec_count,
  output logic                  overflow
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int PTR_W = DEPTH_LOG2;
  localparam int CNT_W = DEPTH_LOG2 + 1;

  logic [63:0]      mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [1:0]       word_idx_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_nxt_s;
  logic             rdy_r;
  logic             overflow_r;
  logic             full_s;
  logic             rd_acc_s;
  logic             pop_s;
  logic             wr_acc_s;
  logic             drop_s;
  logic [63:0]      head_s;

  assign full_s   = (count_r == CNT_W'(DEPTH));
  assign rd_acc_s = data_read & rdy_r;
  assign pop_s    = rd_acc_s & (word_idx_r == 2'd3);
  // A pop in the same cycle frees the head slot, so a capture while full still fits.
  assign wr_acc_s = capture & (~full_s | pop_s);
  assign drop_s   = capture & full_s & ~pop_s;
  assign head_s   = mem_r[rd_ptr_r];

  // Record count next-state from accepted writes and pops.
  always_comb begin
    count_nxt_s = count_r;
    case ({wr_acc_s, pop_s})
      2'b10:   count_nxt_s = count_r + CNT_W'(1);
      2'b01:   count_nxt_s = count_r - CNT_W'(1);
      default: count_nxt_s = count_r;
    endcase
  end

  // Record storage; contents need no reset because every output is masked by rdy.
  always_ff @(posedge clk) begin
    if (wr_acc_s) begin
      mem_r[wr_ptr_r] <= {time_in, data_in};
    end
  end

  // Pointers, word index, count and ready flag.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      word_idx_r <= 2'd0;
      count_r    <= '0;
      rdy_r      <= 1'b0;
    end else begin
      if (wr_acc_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (pop_s) begin
        rd_ptr_r   <= rd_ptr_r + PTR_W'(1);
        word_idx_r <= 2'd0;
      end else if (rd_acc_s) begin
        word_idx_r <= word_idx_r + 2'd1;
      end
      count_r <= count_nxt_s;
      rdy_r   <= (count_nxt_s != '0);
    end
  end

  // Sticky overflow; a drop outranks a coincident clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (clr_ovf) begin
      overflow_r <= 1'b0;
    end
  end

`ifdef READOUT_DROP_COUNT_EN
  logic [15:0] drop_count_r;

  // Saturating drop counter; a drop coincident with a clear restarts the count at one.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drop_count_r <= 16'd0;
    end else if (drop_s && clr_ovf) begin
      drop_count_r <= 16'd1;
    end else if (drop_s) begin
      if (drop_count_r != 16'hFFFF) begin
        drop_count_r <= drop_count_r + 16'd1;
      end
    end else if (clr_ovf) begin
      drop_count_r <= 16'd0;
    end
  end

  assign drop_count = drop_count_r;
`endif

  // Head word selection, forced to zero whenever nothing is buffered.
  always_comb begin
    data_out = 16'h0000;
    if (rdy_r) begin
      case (word_idx_r)
        2'd0:    data_out = head_s[63:48];
        2'd1:    data_out = head_s[47:32];
        2'd2:    data_out = head_s[31:16];
        2'd3:    data_out = head_s[15:0];
        default: data_out = 16'h0000;
      endcase
    end else begin
      data_out = 16'h0000;
    end
  end

  assign rdy       = rdy_r;
  assign rec_count = count_r;
  assign overflow  = overflow_r;

endmodule

// File: tb/tb_timestamp_readout.sv
// Self-checking bench for timestamp_readout: directed vector table, corner sequences, random run vs queue model.
module tb_timestamp_readout;

  localparam int DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        capture;
  logic [47:0] time_in;
  logic [15:0] data_in;
  logic        data_read;
  logic        clr_ovf;
  logic [15:0] data_out;
  logic        rdy;
  logic [2:0]  rec_count;
  logic        overflow;
`ifdef READOUT_DROP_COUNT_EN
  logic [15:0] drop_count;
`endif

  timestamp_readout #(.DEPTH_LOG2(2)) dut (
    .clk       (clk),
    .rst       (rst),
    .capture   (capture),
    .time_in   (time_in),
    .data_in   (data_in),
    .data_read (data_read),
    .clr_ovf   (clr_ovf),
    .data_out  (data_out),
    .rdy       (rdy),
`ifdef READOUT_DROP_COUNT_EN
    .drop_count(drop_count),
`endif
    .rec_count (rec_count),
    .overflow  (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int passes = 0;

  // Reference model: queue of whole records plus the read position inside the head.
  logic [63:0] mq[$];
  int          midx = 0;
  bit          movf = 1'b0;
  int          mdrop = 0;

  typedef struct {
    bit          cap;
    logic [47:0] t;
    logic [15:0] d;
    bit          rd;
    bit          clr;
    bit          e_rdy;
    logic [15:0] e_dout;
    logic [2:0]  e_cnt;
    bit          e_ovf;
  } vec_t;

  vec_t vecs[17];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [15:0] model_dout();
    logic [63:0] rec;
    if (mq.size() == 0) return 16'h0000;
    rec = mq[0];
    return rec[63 - 16*midx -: 16];
  endfunction

  task automatic model_step(input bit cap, input logic [47:0] t, input logic [15:0] d,
                            input bit rd, input bit clr);
    bit rd_ok;
    bit pop;
    bit full;
    bit drop;
    rd_ok = rd && (mq.size() > 0);
    pop   = rd_ok && (midx == 3);
    full  = (mq.size() == DEPTH);
    drop  = cap && full && !pop;
    if (pop) begin
      void'(mq.pop_front());
      midx = 0;
    end else if (rd_ok) begin
      midx++;
    end
    if (cap && !drop) mq.push_back({t, d});
    if (drop) movf = 1'b1;
    else if (clr) movf = 1'b0;
    if (drop && clr) mdrop = 1;
    else if (drop) mdrop = (mdrop < 65535) ? mdrop + 1 : mdrop;
    else if (clr) mdrop = 0;
  endtask

  task automatic check_model(input string tag);
    chk({tag, ".rdy"},  64'(rdy),       64'(mq.size() > 0));
    chk({tag, ".dout"}, 64'(data_out),  64'(model_dout()));
    chk({tag, ".cnt"},  64'(rec_count), 64'(mq.size()));
    chk({tag, ".ovf"},  64'(overflow),  64'(movf));
`ifdef READOUT_DROP_COUNT_EN
    chk({tag, ".drops"}, 64'(drop_count), 64'(mdrop));
`endif
  endtask

  // Drive one cycle of inputs, advance the model, and land 1 time unit after the edge.
  task automatic apply(input bit cap, input logic [47:0] t, input logic [15:0] d,
                       input bit rd, input bit clr);
    capture = cap; time_in = t; data_in = d; data_read = rd; clr_ovf = clr;
    model_step(cap, t, d, rd, clr);
    @(posedge clk);
    #1;
    capture = 1'b0; data_read = 1'b0; clr_ovf = 1'b0;
  endtask

  task automatic model_reset();
    mq.delete();
    midx = 0; movf = 1'b0; mdrop = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    capture = 1'b0; time_in = '0; data_in = '0; data_read = 1'b0; clr_ovf = 1'b0;
    rst = 1'b1;
    model_reset();
    #2;
    chk("reset.rdy",  64'(rdy), 64'd0);
    chk("reset.dout", 64'(data_out), 64'd0);
    chk("reset.cnt",  64'(rec_count), 64'd0);
    chk("reset.ovf",  64'(overflow), 64'd0);
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;

    vecs[0]  = '{1'b1, 48'h1234_5678_9ABC, 16'h00EF, 1'b0, 1'b0, 1'b1, 16'h1234, 3'd1, 1'b0};
    vecs[1]  = '{1'b0, 48'h0,              16'h0,    1'b1, 1'b0, 1'b1, 16'h5678, 3'd1, 1'b0};
    vecs[2]  = '{1'b0, 48'h0,              16'h0,    1'b1, 1'b0, 1'b1, 16'h9ABC, 3'd1, 1'b0};
    vecs[3]  = '{1'b0, 48'h0,              16'h0,    1'b1, 1'b0, 1'b1, 16'h00EF, 3'd1, 1'b0};
    vecs[4]  = '{1'b0, 48'h0,              16'h0,    1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0};
    vecs[5]  = '{1'b0, 48'h0,              16'h0,    1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0};
    vecs[6]  = '{1'b0, 48'h0,              16'h0,    1'b1, 1'b0, 1'b0, 16'h0000, 3'd0, 1'b0};
    vecs[7]  = '{1'b1, 48'hAAAA_BBBB_CCCC, 16'h1111, 1'b0, 1'b0, 1'b1, 16'hAAAA, 3'd1, 1'b0};
    vecs[8]  = '{1'b1, 48'h2000_2001_2002, 16'h2003, 1'b1, 1'b0, 1'b1, 16'hBBBB, 3'd2, 1'b0};
    vecs[9]  = '{1'b1, 48'h3000_3001_3002, 16'h3003, 1'b0, 1'b0, 1'b1, 16'hBBBB, 3'd3, 1'b0};
    vecs[10] = '{1'b1, 48'h4000_4001_4002, 16'h4003, 1'b0, 1'b0, 1'b1, 16'hBBBB, 3'd4, 1'b0};
    vecs[11] = '{1'b1, 48'h5000_5001_5002, 16'h5003, 1'b0, 1'b0, 1'b1, 16'hBBBB, 3'd4, 1'b1};
    vecs[12] = '{1'b1, 48'h5000_5001_5002, 16'h5003, 1'b0, 1'b1, 1'b1, 16'hBBBB, 3'd4, 1'b1};
    vecs[13] = '{1'b0, 48'h0,              16'h0,    1'b0, 1'b1, 1'b1, 16'hBBBB, 3'd4, 1'b0};
    vecs[14] = '{1'b0, 48'h0,              16'h0,    1'b1, 1'b0, 1'b1, 16'hCCCC, 3'd4, 1'b0};
    vecs[15] = '{1'b0, 48'h0,              16'h0,    1'b1, 1'b0, 1'b1, 16'h1111, 3'd4, 1'b0};
    vecs[16] = '{1'b1, 48'h6000_6001_6002, 16'h6003, 1'b1, 1'b0, 1'b1, 16'h2000, 3'd4, 1'b0};

    for (int i = 0; i < 17; i++) begin
      apply(vecs[i].cap, vecs[i].t, vecs[i].d, vecs[i].rd, vecs[i].clr);
      chk($sformatf("vec%0d.rdy", i),  64'(rdy),       64'(vecs[i].e_rdy));
      chk($sformatf("vec%0d.dout", i), 64'(data_out),  64'(vecs[i].e_dout));
      chk($sformatf("vec%0d.cnt", i),  64'(rec_count), 64'(vecs[i].e_cnt));
      chk($sformatf("vec%0d.ovf", i),  64'(overflow),  64'(vecs[i].e_ovf));
      check_model($sformatf("vec%0d.model", i));
    end

    // Drain: records 2,3,4,6 in order, the dropped record 5 never appears.
    for (int r = 0; r < 4; r++) begin
      for (int w = 0; w < 4; w++) begin
        logic [15:0] base;
        base = (r == 3) ? 16'h6000 : 16'(16'h2000 + 16'h1000 * r);
        chk($sformatf("drain%0d_%0d", r, w), 64'(data_out), 64'(base + 16'(w)));
        apply(1'b0, 48'h0, 16'h0, 1'b1, 1'b0);
      end
    end
    chk("drain.empty.rdy", 64'(rdy), 64'd0);
    chk("drain.empty.cnt", 64'(rec_count), 64'd0);

    // Async reset in the middle of a partially read record.
    apply(1'b1, 48'hDEAD_BEEF_CAFE, 16'hF00D, 1'b0, 1'b0);
    apply(1'b0, 48'h0, 16'h0, 1'b1, 1'b0);
    apply(1'b0, 48'h0, 16'h0, 1'b1, 1'b0);
    chk("midrec.dout", 64'(data_out), 64'hCAFE);
    #2 rst = 1'b1;
    #1;
    model_reset();
    chk("midrst.rdy",  64'(rdy), 64'd0);
    chk("midrst.cnt",  64'(rec_count), 64'd0);
    chk("midrst.dout", 64'(data_out), 64'd0);
    @(negedge clk); rst = 1'b0;
    apply(1'b1, 48'h0102_0304_0506, 16'h0708, 1'b0, 1'b0);
    chk("postrst.dout", 64'(data_out), 64'h0102);
    chk("postrst.cnt",  64'(rec_count), 64'd1);
    check_model("postrst");

    // Randomized traffic against the queue model.
    for (int n = 0; n < 600; n++) begin
      bit cap, rd, clr;
      logic [47:0] t;
      logic [15:0] d;
      cap = ($urandom_range(0, 99) < 50);
      rd  = ($urandom_range(0, 99) < 55);
      clr = ($urandom_range(0, 99) < 6);
      t   = {16'($urandom), 32'($urandom)};
      d   = 16'($urandom);
      apply(cap, t, d, rd, clr);
      check_model($sformatf("rand%0d", n));
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
